// File: rtl/arm_pkg.sv
// Shared types and constants for the ARM core pipeline hazard logic.
package arm_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    typedef struct packed {
        logic       valid;
        logic [3:0] ra1;
        logic [3:0] ra2;
        logic [3:0] wa3;
        logic       reg_write;
        logic       mem_to_reg;
        logic       pc_src;
    } stage_tag_t;

    localparam logic [3:0] REG_PC = 4'd15;

    // True when a live stage will write register r back to the register file.
    function automatic logic writes_reg(input logic valid, input logic reg_write,
                                        input logic [3:0] wa3, input logic [3:0] r);
        return valid & reg_write & (wa3 == r);
    endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// Operand forwarding select for one Execute-stage source tag.
module hazard_fwd_sel
    import arm_pkg::*;
(
    input  logic [3:0] src_i,
    input  logic       m_valid_i,
    input  logic       m_reg_write_i,
    input  logic [3:0] m_wa3_i,
    input  logic       w_valid_i,
    input  logic       w_reg_write_i,
    input  logic [3:0] w_wa3_i,
    output logic [1:0] sel_o
);

    fwd_sel_t sel_s;

    // Nearest producer wins; R15 reads come from the datapath's PC+8, never a bypass.
    always_comb begin
        sel_s = FWD_RF;
        if (src_i == REG_PC) begin
            sel_s = FWD_RF;
        end else if (writes_reg(m_valid_i, m_reg_write_i, m_wa3_i, src_i)) begin
            sel_s = FWD_M;
        end else if (writes_reg(w_valid_i, w_reg_write_i, w_wa3_i, src_i)) begin
            sel_s = FWD_W;
        end else begin
            sel_s = FWD_RF;
        end
    end

    assign sel_o = sel_s;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: shadow E/M/W tag pipeline, forwarding selects,
// stall/flush enables and saturating performance counters.
module hazard_ctrl
    import arm_pkg::*;
#(
    parameter int CW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    ra1_d,
    input  logic [3:0]    ra2_d,
    input  logic [3:0]    wa3_d,
    input  logic          reg_write_d,
    input  logic          mem_to_reg_d,
    input  logic          pc_src_d,
    input  logic          cond_ex_e,
    input  logic          branch_taken_e,
    output logic [1:0]    fwd_a_e,
    output logic [1:0]    fwd_b_e,
    output logic          stall_f,
    output logic          stall_d,
    output logic          flush_d,
    output logic          flush_e,
    output logic [CW-1:0] stall_cnt,
    output logic [CW-1:0] flush_cnt
);

    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    stage_tag_t    e_tag_q, e_tag_d;
    stage_tag_t    m_tag_q, m_tag_d;
    stage_tag_t    w_tag_q;
    logic [CW-1:0] stall_cnt_q, flush_cnt_q;

    logic          ldr_stall_s;
    logic          pc_pend_s;
    logic          stall_f_s, stall_d_s, flush_d_s, flush_e_s;
    logic [1:0]    fwd_a_s, fwd_b_s;

    // Load-use check ignores the E condition result: stalling on a skipped load is harmless.
    assign ldr_stall_s = e_tag_q.valid & e_tag_q.mem_to_reg & (e_tag_q.wa3 != REG_PC)
                       & ((e_tag_q.wa3 == ra1_d) | (e_tag_q.wa3 == ra2_d));
    assign pc_pend_s   = pc_src_d | e_tag_q.pc_src | m_tag_q.pc_src;

    // Next-state tags for E (bubble on flush) and M (writes gated by condition).
    always_comb begin
        e_tag_d = '0;
        if (ldr_stall_s | branch_taken_e) begin
            e_tag_d = '0;
        end else begin
            e_tag_d.valid      = 1'b1;
            e_tag_d.ra1        = ra1_d;
            e_tag_d.ra2        = ra2_d;
            e_tag_d.wa3        = wa3_d;
            e_tag_d.reg_write  = reg_write_d;
            e_tag_d.mem_to_reg = mem_to_reg_d;
            e_tag_d.pc_src     = pc_src_d;
        end
        m_tag_d           = e_tag_q;
        m_tag_d.reg_write = e_tag_q.reg_write & cond_ex_e;
        m_tag_d.pc_src    = e_tag_q.pc_src & cond_ex_e;
    end

    // Shadow pipeline registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            e_tag_q <= '0;
            m_tag_q <= '0;
            w_tag_q <= '0;
        end else begin
            e_tag_q <= e_tag_d;
            m_tag_q <= m_tag_d;
            w_tag_q <= m_tag_q;
        end
    end

    hazard_fwd_sel u_fwd_a (
        .src_i         (e_tag_q.ra1),
        .m_valid_i     (m_tag_q.valid),
        .m_reg_write_i (m_tag_q.reg_write),
        .m_wa3_i       (m_tag_q.wa3),
        .w_valid_i     (w_tag_q.valid),
        .w_reg_write_i (w_tag_q.reg_write),
        .w_wa3_i       (w_tag_q.wa3),
        .sel_o         (fwd_a_s)
    );

    hazard_fwd_sel u_fwd_b (
        .src_i         (e_tag_q.ra2),
        .m_valid_i     (m_tag_q.valid),
        .m_reg_write_i (m_tag_q.reg_write),
        .m_wa3_i       (m_tag_q.wa3),
        .w_valid_i     (w_tag_q.valid),
        .w_reg_write_i (w_tag_q.reg_write),
        .w_wa3_i       (w_tag_q.wa3),
        .sel_o         (fwd_b_s)
    );

    // Stall/flush enables; reset forces both pipeline registers to flush.
    always_comb begin
        stall_f_s = 1'b0;
        stall_d_s = 1'b0;
        flush_d_s = 1'b1;
        flush_e_s = 1'b1;
        if (rst) begin
            stall_f_s = 1'b0;
            stall_d_s = 1'b0;
            flush_d_s = 1'b1;
            flush_e_s = 1'b1;
        end else begin
            stall_f_s = ldr_stall_s | pc_pend_s;
            stall_d_s = ldr_stall_s & ~branch_taken_e;
            flush_d_s = pc_pend_s | w_tag_q.pc_src | branch_taken_e;
            flush_e_s = ldr_stall_s | branch_taken_e;
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= {CW{1'b0}};
            flush_cnt_q <= {CW{1'b0}};
        end else begin
            if (stall_d_s && (stall_cnt_q != CNT_MAX)) begin
                stall_cnt_q <= stall_cnt_q + CNT_ONE;
            end
            if (branch_taken_e && (flush_cnt_q != CNT_MAX)) begin
                flush_cnt_q <= flush_cnt_q + CNT_ONE;
            end
        end
    end

    assign fwd_a_e   = rst ? 2'b00 : fwd_a_s;
    assign fwd_b_e   = rst ? 2'b00 : fwd_b_s;
    assign stall_f   = stall_f_s;
    assign stall_d   = stall_d_s;
    assign flush_d   = flush_d_s;
    assign flush_e   = flush_e_s;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

    // Tag fields carried down the shadow pipe for visibility but not consumed downstream.
    logic unused_tag_s;
    assign unused_tag_s = ^{m_tag_q.ra1, m_tag_q.ra2, m_tag_q.mem_to_reg,
                            w_tag_q.ra1, w_tag_q.ra2, w_tag_q.mem_to_reg};

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl; counters narrowed to exercise saturation.
module tb_hazard_ctrl;

    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    ra1_d, ra2_d, wa3_d;
    logic          reg_write_d, mem_to_reg_d, pc_src_d;
    logic          cond_ex_e, branch_taken_e;
    logic [1:0]    fwd_a_e, fwd_b_e;
    logic          stall_f, stall_d, flush_d, flush_e;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int total_cnt = 0;
    int bad_cnt   = 0;

    hazard_ctrl #(.CW(CW)) dut (
        .clk            (clk),
        .rst            (rst),
        .ra1_d          (ra1_d),
        .ra2_d          (ra2_d),
        .wa3_d          (wa3_d),
        .reg_write_d    (reg_write_d),
        .mem_to_reg_d   (mem_to_reg_d),
        .pc_src_d       (pc_src_d),
        .cond_ex_e      (cond_ex_e),
        .branch_taken_e (branch_taken_e),
        .fwd_a_e        (fwd_a_e),
        .fwd_b_e        (fwd_b_e),
        .stall_f        (stall_f),
        .stall_d        (stall_d),
        .flush_d        (flush_d),
        .flush_e        (flush_e),
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_d(input logic [3:0] a1, input logic [3:0] a2, input logic [3:0] w,
                         input logic rw, input logic mr, input logic pc);
        ra1_d = a1; ra2_d = a2; wa3_d = w;
        reg_write_d = rw; mem_to_reg_d = mr; pc_src_d = pc;
        #1;
    endtask

    task automatic nop();
        set_d(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_sf(input string tag, input logic sf, input logic sd,
                            input logic fd, input logic fe);
        check_eq({tag, "_stall_f"}, {31'd0, stall_f}, {31'd0, sf});
        check_eq({tag, "_stall_d"}, {31'd0, stall_d}, {31'd0, sd});
        check_eq({tag, "_flush_d"}, {31'd0, flush_d}, {31'd0, fd});
        check_eq({tag, "_flush_e"}, {31'd0, flush_e}, {31'd0, fe});
    endtask

    task automatic check_fwd(input string tag, input logic [1:0] a, input logic [1:0] b);
        check_eq({tag, "_fwd_a"}, {30'd0, fwd_a_e}, {30'd0, a});
        check_eq({tag, "_fwd_b"}, {30'd0, fwd_b_e}, {30'd0, b});
    endtask

    initial begin
        rst = 1'b1; cond_ex_e = 1'b1; branch_taken_e = 1'b0;
        set_d(4'd1, 4'd1, 4'd1, 1'b1, 1'b0, 1'b1);
        tick(); tick();
        // Reset: pending PC write on D input must not stall.
        check_sf("rst", 1'b0, 1'b0, 1'b1, 1'b1);
        check_fwd("rst", 2'b00, 2'b00);
        check_eq("rst_stall_cnt", {29'd0, stall_cnt}, 32'd0);
        check_eq("rst_flush_cnt", {29'd0, flush_cnt}, 32'd0);

        // ADD R1,R2,R3 ; ADD R4,R1,R5
        rst = 1'b0;
        set_d(4'd2, 4'd3, 4'd1, 1'b1, 1'b0, 1'b0); tick();
        set_d(4'd1, 4'd5, 4'd4, 1'b1, 1'b0, 1'b0);
        check_sf("alu_dep", 1'b0, 1'b0, 1'b0, 1'b0);
        tick(); nop();
        check_fwd("fwd_m", 2'b10, 2'b00);

        // ADD R1 ; unrelated ; SUB R6,R7,R1
        set_d(4'd2, 4'd3, 4'd1, 1'b1, 1'b0, 1'b0); tick();
        set_d(4'd8, 4'd9, 4'd10, 1'b1, 1'b0, 1'b0); tick();
        set_d(4'd7, 4'd1, 4'd6, 1'b1, 1'b0, 1'b0); tick(); nop();
        check_fwd("fwd_w", 2'b00, 2'b01);

        // Producer writes R15, consumer reads R15 on both ports
        set_d(4'd0, 4'd0, 4'd15, 1'b1, 1'b0, 1'b0); tick();
        set_d(4'd15, 4'd15, 4'd9, 1'b1, 1'b0, 1'b0); tick();
        check_fwd("fwd_r15", 2'b00, 2'b00);

        // LDR R3,[R0] ; ADD R4,R3,R3
        set_d(4'd0, 4'd0, 4'd3, 1'b1, 1'b1, 1'b0); tick();
        set_d(4'd3, 4'd3, 4'd4, 1'b1, 1'b0, 1'b0);
        check_sf("ldr_use", 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        check_sf("ldr_bubble", 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("ldr_stall_cnt", {29'd0, stall_cnt}, 32'd1);
        tick(); nop();
        check_fwd("ldr_fwd", 2'b01, 2'b01);

        // Branch taken while a load-use stall is pending
        set_d(4'd0, 4'd0, 4'd5, 1'b1, 1'b1, 1'b0); tick();
        set_d(4'd5, 4'd0, 4'd6, 1'b1, 1'b0, 1'b0);
        branch_taken_e = 1'b1; #1;
        check_sf("br_ldr", 1'b1, 1'b0, 1'b1, 1'b1);
        tick(); branch_taken_e = 1'b0; nop();
        check_eq("br_flush_cnt", {29'd0, flush_cnt}, 32'd1);
        check_eq("br_stall_cnt", {29'd0, stall_cnt}, 32'd1);

        // MOV PC: stall_f for 3 cycles, flush_d for 4
        tick(); tick();
        set_d(4'd0, 4'd0, 4'd15, 1'b1, 1'b0, 1'b1);
        check_sf("pc_c0", 1'b1, 1'b0, 1'b1, 1'b0);
        tick(); nop();
        check_sf("pc_c1", 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        check_sf("pc_c2", 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        check_sf("pc_c3", 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        check_sf("pc_c4", 1'b0, 1'b0, 1'b0, 1'b0);

        // Flush counter saturates at 7 (1 already counted + 8 more)
        branch_taken_e = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        branch_taken_e = 1'b0; #1;
        check_eq("flush_sat", {29'd0, flush_cnt}, 32'd7);
        check_eq("sat_stall_cnt", {29'd0, stall_cnt}, 32'd1);

        // Condition-failed producer must not forward
        tick();
        set_d(4'd2, 4'd3, 4'd1, 1'b1, 1'b0, 1'b0); tick();
        set_d(4'd1, 4'd1, 4'd4, 1'b1, 1'b0, 1'b0);
        cond_ex_e = 1'b0; tick(); cond_ex_e = 1'b1; nop();
        check_fwd("cond_fail", 2'b00, 2'b00);

        // Reset in the middle of a load-use stall
        set_d(4'd0, 4'd0, 4'd3, 1'b1, 1'b1, 1'b0); tick();
        set_d(4'd3, 4'd0, 4'd4, 1'b1, 1'b0, 1'b0);
        check_sf("pre_rst", 1'b1, 1'b1, 1'b0, 1'b1);
        rst = 1'b1; #1;
        check_sf("in_rst", 1'b0, 1'b0, 1'b1, 1'b1);
        tick(); rst = 1'b0; #1;
        check_sf("post_rst", 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("post_rst_stall_cnt", {29'd0, stall_cnt}, 32'd0);
        check_eq("post_rst_flush_cnt", {29'd0, flush_cnt}, 32'd0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
